subcore_dispatcher: RTL

- Sits between the main core and the SUBCORE_NUM subcores.
- Accepts fork requests from main (start PC plus two data words), picks an idle subcore, and drives that subcore's exec_requested, requested_pc and data inputs.
- Tracks per-subcore busy state from the subcore_ended pulses.
- Gives main a join handshake that completes once every subcore is idle.

---
 rtl/subcore_dispatcher.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/subcore_dispatcher.sv
// Fork/join dispatcher between the main core and SUBCORE_NUM subcores.
// Define DISPATCH_RR_EN for round-robin core selection; default is lowest-index priority.
module subcore_dispatcher #(
  parameter int unsigned SUBCORE_NUM = 4,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   fork_valid,
  output logic                   fork_ready,
  input  logic [PC_W-1:0]        fork_pc,
  input  logic [DATA_W-1:0]      fork_u,
  input  logic [DATA_W-1:0]      fork_l,
  output logic [2:0]             fork_core,
  input  logic                   join_req,
  output logic                   join_done,
  output logic [SUBCORE_NUM-1:0] exec_requested,
  output logic [PC_W-1:0]        requested_pc,
  output logic [DATA_W-1:0]      u_n_out,
  output logic [DATA_W-1:0]      l_n_out,
  input  logic [SUBCORE_NUM-1:0] subcore_ended,
  output logic [SUBCORE_NUM-1:0] busy,
  output logic                   err
);

  localparam int unsigned IdxW = $clog2(SUBCORE_NUM);

  typedef enum logic [0:0] {StIdle, StJoin} state_e;

  state_e                 state_q, state_d;
  logic [SUBCORE_NUM-1:0] busy_q, busy_d;
  logic [SUBCORE_NUM-1:0] exec_q, exec_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [DATA_W-1:0]      u_q, u_d;
  logic [DATA_W-1:0]      l_q, l_d;
  logic                   join_done_q, join_done_d;
  logic                   err_q, err_d;
  logic [IdxW-1:0]        sel_idx;
  logic                   sel_found;
  logic                   accept;

`ifdef DISPATCH_RR_EN
  localparam int unsigned CandW = IdxW + 1;

  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [CandW-1:0] cand;

  // First idle core at or after the pointer, wrapping modulo SUBCORE_NUM.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < SUBCORE_NUM; i++) begin
      cand = {1'b0, ptr_q} + CandW'(i);
      if (cand >= CandW'(SUBCORE_NUM)) begin
        cand = cand - CandW'(SUBCORE_NUM);
      end
      if (!sel_found && !busy_q[cand[IdxW-1:0]]) begin
        sel_idx   = cand[IdxW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (sel_idx == IdxW'(SUBCORE_NUM - 1)) ? '0 : sel_idx + 1'b1;
    end
  end
`else
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < SUBCORE_NUM; i++) begin
      if (!sel_found && !busy_q[i]) begin
        sel_idx   = IdxW'(i);
        sel_found = 1'b1;
      end
    end
  end
`endif

  // Readiness uses registered busy only, so a same-cycle completion frees a core a cycle later.
  always_comb begin
    fork_ready = (state_q == StIdle) && !(&busy_q);
    accept     = fork_valid && fork_ready;
    fork_core  = 3'(sel_idx);
  end

  always_comb begin
    busy_d      = busy_q & ~subcore_ended;
    err_d       = err_q | (|(subcore_ended & ~busy_q));
    exec_d      = '0;
    pc_d        = pc_q;
    u_d         = u_q;
    l_d         = l_q;
    join_done_d = 1'b0;
    state_d     = state_q;

    if (accept) begin
      busy_d[sel_idx] = 1'b1;
      exec_d[sel_idx] = 1'b1;
      pc_d            = fork_pc;
      u_d             = fork_u;
      l_d             = fork_l;
    end

    case (state_q)
      StIdle: begin
        if (join_req && !accept) begin
          state_d = StJoin;
        end
      end
      StJoin: begin
        if (busy_q == '0) begin
          join_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      busy_q      <= '0;
      exec_q      <= '0;
      pc_q        <= '0;
      u_q         <= '0;
      l_q         <= '0;
      join_done_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef DISPATCH_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      exec_q      <= exec_d;
      pc_q        <= pc_d;
      u_q         <= u_d;
      l_q         <= l_d;
      join_done_q <= join_done_d;
      err_q       <= err_d;
`ifdef DISPATCH_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign exec_requested = exec_q;
  assign requested_pc   = pc_q;
  assign u_n_out        = u_q;
  assign l_n_out        = l_q;
  assign join_done      = join_done_q;
  assign err            = err_q;

endmodule
